// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: mode selection and the
// direction state that drives the bounce FSM.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

endpackage

// File: rtl/led_sequencer_if.sv
// Control and status bundle between the board controls and the sequencer.
// The master side drives the controls; the sequencer (slave) returns the
// registered LED pattern and status.
interface led_sequencer_if
  import led_pkg::*;
#(
  parameter int NLEDS = 8,
  parameter int DIVW  = 16
) ();

  localparam int PW = $clog2(NLEDS);

  logic              enable;
  logic              restart;
  mode_t             mode;
  logic [DIVW-1:0]   period;
  logic [NLEDS-1:0]  leds;
  logic [PW-1:0]     pos;
  logic              dir;
  logic              step;
  logic              cycle_done;

  modport master (
    output enable, restart, mode, period,
    input  leds, pos, dir, step, cycle_done
  );

  modport slave (
    input  enable, restart, mode, period,
    output leds, pos, dir, step, cycle_done
  );

endinterface

// File: rtl/led_sequencer_prescaler.sv
// Programmable prescaler: emits a tick once every period+1 running cycles.
// The count only advances while run is high, so pausing keeps the exact
// phase. Lowering period below the current count lets the counter roll over
// at 2^DIVW before the next match.
module led_prescaler #(
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic            clear,
  input  logic [DIVW-1:0] period,
  output logic            tick
);

  logic [DIVW-1:0] count_reg;

  assign tick = run && !clear && (count_reg == period);

  // Count cycles while running; reset/clear return to zero, idle freezes.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= (count_reg == period) ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: walks a position across NLEDS outputs on each
// prescaler tick (bounce, wrap, bar or hold) and renders it as one-hot or
// bar pattern. All outputs are registered.
module led_sequencer
  import led_pkg::*;
#(
  parameter int  NLEDS = 8,
  parameter int  DIVW  = 16,
  localparam int PW    = $clog2(NLEDS)
) (
  input  logic           clk,
  input  logic           resetn,
  led_sequencer_if.slave bus
);

  localparam logic [PW-1:0] POS_MAX = PW'(NLEDS - 1);

  logic             run;
  logic             tick;
  logic [PW-1:0]    pos_reg;
  logic [PW-1:0]    pos_next;
  dir_t             dir_reg;
  dir_t             dir_next;
  logic             cd_next;
  logic [NLEDS-1:0] leds_reg;
  logic [NLEDS-1:0] leds_next;
  logic             step_reg;
  logic             cd_reg;

  // HOLD behaves like a pause of the prescaler, but the pattern still renders.
  assign run = bus.enable && (bus.mode != MODE_HOLD);

  led_prescaler #(
    .DIVW (DIVW)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .clear  (bus.restart),
    .period (bus.period),
    .tick   (tick)
  );

  // Next position/direction for this tick; end positions dwell one tick.
  always_comb begin
    pos_next = pos_reg;
    dir_next = dir_reg;
    cd_next  = 1'b0;
    if (tick) begin
      case (bus.mode)
        MODE_WRAP: begin
          dir_next = DIR_UP;
          if (pos_reg == POS_MAX) begin
            pos_next = '0;
            cd_next  = 1'b1;
          end else begin
            pos_next = pos_reg + 1'b1;
          end
        end
        MODE_BOUNCE, MODE_BAR: begin
          if (dir_reg == DIR_UP) begin
            if (pos_reg == POS_MAX) begin
              dir_next = DIR_DOWN;
            end else begin
              pos_next = pos_reg + 1'b1;
            end
          end else begin
            if (pos_reg == '0) begin
              dir_next = DIR_UP;
              cd_next  = 1'b1;
            end else begin
              pos_next = pos_reg - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pattern decode from the next position so a mode change re-renders at once.
  for (genvar gi = 0; gi < NLEDS; gi++) begin : g_pattern
    localparam logic [PW-1:0] IDX = PW'(gi);
    assign leds_next[gi] = (bus.mode == MODE_BAR) ? (IDX <= pos_next)
                                                  : (IDX == pos_next);
  end

  // State and output registers: reset, then restart, then freeze, then tick.
  always_ff @(posedge clk) begin
    if (!resetn || bus.restart) begin
      pos_reg  <= '0;
      dir_reg  <= DIR_DOWN;
      leds_reg <= NLEDS'(1);
      step_reg <= 1'b0;
      cd_reg   <= 1'b0;
    end else if (!bus.enable) begin
      step_reg <= 1'b0;
      cd_reg   <= 1'b0;
    end else begin
      pos_reg  <= pos_next;
      dir_reg  <= dir_next;
      leds_reg <= leds_next;
      step_reg <= tick;
      cd_reg   <= cd_next;
    end
  end

  assign bus.leds       = leds_reg;
  assign bus.pos        = pos_reg;
  assign bus.dir        = dir_reg;
  assign bus.step       = step_reg;
  assign bus.cycle_done = cd_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: the stimulus pushes the expected
// state of every step pulse; per-DUT monitors pop and compare on each step.
// Non-step behaviour (reset, freeze, restart, prescaler timing) is checked
// directly by the stimulus process.
module tb_led_sequencer;
  import led_pkg::*;

  typedef struct {
    logic [63:0] leds;
    int          pos;
    logic        dir;
    logic        cd;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q13[$];

  always #5 clk = ~clk;

  led_sequencer_if #(.NLEDS(8),  .DIVW(8)) if8  ();
  led_sequencer_if #(.NLEDS(2),  .DIVW(8)) if2  ();
  led_sequencer_if #(.NLEDS(13), .DIVW(8)) if13 ();

  led_sequencer #(.NLEDS(8),  .DIVW(8)) u_dut8  (.clk(clk), .resetn(resetn), .bus(if8));
  led_sequencer #(.NLEDS(2),  .DIVW(8)) u_dut2  (.clk(clk), .resetn(resetn), .bus(if2));
  led_sequencer #(.NLEDS(13), .DIVW(8)) u_dut13 (.clk(clk), .resetn(resetn), .bus(if13));

  // Hand-derived bounce position after tick k (k from 1) for an n-LED bank.
  function automatic int bpos(input int n, input int k);
    int c;
    c = (k - 1) % (2 * n);
    if (c == 0) return 0;
    if (c < n) return c;
    if (c == n) return n - 1;
    return 2 * n - 1 - c;
  endfunction

  function automatic exp_t mk(input int pos, input logic dir, input logic cd);
    exp_t e;
    logic [63:0] one;
    one    = 64'd1;
    e.leds = one << pos;
    e.pos  = pos;
    e.dir  = dir;
    e.cd   = cd;
    return e;
  endfunction

  function automatic exp_t mk_bounce(input int n, input int k);
    int c;
    c = (k - 1) % (2 * n);
    return mk(bpos(n, k), (c < n), (c == 0));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input exp_t e, input logic [63:0] leds,
                        input logic [63:0] pos, input logic dir, input logic cd);
    n_checks++;
    if (leds !== e.leds || pos !== 64'(e.pos) || dir !== e.dir || cd !== e.cd) begin
      n_fail++;
      $display("FAIL %s step: got leds=%0h pos=%0d dir=%0b cd=%0b expected leds=%0h pos=%0d dir=%0b cd=%0b",
               tag, leds, pos, dir, cd, e.leds, e.pos, e.dir, e.cd);
    end else begin
      $display("%s step: leds=%0h pos=%0d dir=%0b cd=%0b", tag, leds, pos, dir, cd);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the 8-LED DUT.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (if8.step === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut8 step: unexpected pulse leds=%0h pos=%0d, none expected", if8.leds, if8.pos);
      end else begin
        e = q8.pop_front();
        sb_cmp("dut8", e, 64'(if8.leds), 64'(if8.pos), if8.dir, if8.cycle_done);
      end
    end else begin
      chk("dut8 cycle_done without step", 64'(if8.cycle_done), 64'd0);
    end
  end

  // Monitor for the 2-LED DUT.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (if2.step === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 step: unexpected pulse pos=%0d, none expected", if2.pos);
      end else begin
        e = q2.pop_front();
        sb_cmp("dut2", e, 64'(if2.leds), 64'(if2.pos), if2.dir, if2.cycle_done);
      end
    end
  end

  // Monitor for the 13-LED DUT.
  always @(negedge clk) begin : mon13
    exp_t e;
    if (if13.step === 1'b1) begin
      if (q13.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut13 step: unexpected pulse pos=%0d, none expected", if13.pos);
      end else begin
        e = q13.pop_front();
        sb_cmp("dut13", e, 64'(if13.leds), 64'(if13.pos), if13.dir, if13.cycle_done);
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    resetn = 1'b0;
    if8.enable  = 1'b1; if8.restart  = 1'b0; if8.mode  = MODE_BOUNCE; if8.period  = 8'd0;
    if2.enable  = 1'b1; if2.restart  = 1'b0; if2.mode  = MODE_BOUNCE; if2.period  = 8'd0;
    if13.enable = 1'b1; if13.restart = 1'b0; if13.mode = MODE_BOUNCE; if13.period = 8'd0;
    cyc(2);

    // Reset state.
    chk("reset leds", 64'(if8.leds), 64'h1);
    chk("reset pos", 64'(if8.pos), 64'd0);
    chk("reset dir", 64'(if8.dir), 64'd0);
    chk("reset step", 64'(if8.step), 64'd0);
    chk("reset cycle_done", 64'(if8.cycle_done), 64'd0);
    chk("reset leds n2", 64'(if2.leds), 64'h1);
    chk("reset leds n13", 64'(if13.leds), 64'h1);

    // Bounce from reset, period 0, on all three widths.
    for (int k = 1; k <= 28; k++) begin
      q8.push_back(mk_bounce(8, k));
      q2.push_back(mk_bounce(2, k));
      q13.push_back(mk_bounce(13, k));
    end
    resetn = 1'b1;
    cyc(28);
    if2.enable  = 1'b0;
    if13.enable = 1'b0;

    // Restart while a tick coincides (period 0).
    if8.restart = 1'b1;
    cyc(1);
    chk("restart leds", 64'(if8.leds), 64'h1);
    chk("restart pos", 64'(if8.pos), 64'd0);
    chk("restart step", 64'(if8.step), 64'd0);

    // Wrap mode with period 3: step every 4th cycle.
    if8.restart = 1'b0;
    if8.mode    = MODE_WRAP;
    if8.period  = 8'd3;
    for (int t = 1; t <= 9; t++) q8.push_back(mk(t % 8, 1'b1, (t % 8) == 0));
    for (int j = 1; j <= 36; j++) begin
      cyc(1);
      chk("prescaler step period 3", 64'(if8.step), 64'((j % 4) == 0));
    end

    // Drop period 3 -> 0 with count at 2: no tick until the count rolls over.
    cyc(2);
    chk("count 2 no step", 64'(if8.step), 64'd0);
    if8.period = 8'd0;
    cnt = 0;
    for (int n = 1; n <= 254; n++) begin
      cyc(1);
      if (if8.step === 1'b1) cnt++;
    end
    chk("period drop steps before rollover", 64'(cnt), 64'd0);
    for (int t = 2; t <= 4; t++) q8.push_back(mk(t, 1'b1, 1'b0));
    for (int n = 1; n <= 3; n++) begin
      cyc(1);
      chk("period 0 step every cycle", 64'(if8.step), 64'd1);
    end

    // Freeze with enable=0 at pos 4, count 2.
    if8.period = 8'd3;
    cyc(2);
    chk("pre-freeze no step", 64'(if8.step), 64'd0);
    if8.enable = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc(1);
      chk("freeze leds", 64'(if8.leds), 64'h10);
      chk("freeze pos", 64'(if8.pos), 64'd4);
      chk("freeze step", 64'(if8.step), 64'd0);
    end
    if8.enable = 1'b1;
    q8.push_back(mk(5, 1'b1, 1'b0));
    cyc(1);
    chk("resume first cycle no step", 64'(if8.step), 64'd0);
    cyc(1);
    chk("resume step at held count", 64'(if8.step), 64'd1);

    // Bar render without a tick.
    if8.mode   = MODE_BAR;
    if8.period = 8'd200;
    cyc(1);
    chk("bar leds pos 5", 64'(if8.leds), 64'h3F);
    chk("bar no step", 64'(if8.step), 64'd0);

    // HOLD for 10 cycles at count 1.
    if8.mode   = MODE_HOLD;
    if8.period = 8'd3;
    for (int n = 1; n <= 10; n++) begin
      cyc(1);
      chk("hold leds", 64'(if8.leds), 64'h20);
      chk("hold pos", 64'(if8.pos), 64'd5);
      chk("hold step", 64'(if8.step), 64'd0);
    end
    if8.mode = MODE_WRAP;
    q8.push_back(mk(6, 1'b1, 1'b0));
    for (int n = 1; n <= 3; n++) begin
      cyc(1);
      chk("leave hold step timing", 64'(if8.step), 64'(n == 3));
    end

    // Bounce up to pos 7, then restart on the dwell tick.
    if8.mode = MODE_BOUNCE;
    q8.push_back(mk(7, 1'b1, 1'b0));
    for (int n = 1; n <= 7; n++) begin
      cyc(1);
      chk("bounce to 7 step timing", 64'(if8.step), 64'(n == 4));
    end
    if8.restart = 1'b1;
    cyc(1);
    chk("restart over tick leds", 64'(if8.leds), 64'h1);
    chk("restart over tick dir", 64'(if8.dir), 64'd0);
    chk("restart over tick step", 64'(if8.step), 64'd0);
    chk("restart over tick cycle_done", 64'(if8.cycle_done), 64'd0);

    // Reset with enable=1, restart=0 mid-sequence.
    if8.restart = 1'b0;
    if8.period  = 8'd0;
    for (int k = 1; k <= 3; k++) q8.push_back(mk_bounce(8, k));
    cyc(3);
    resetn = 1'b0;
    cyc(1);
    chk("reset prio leds", 64'(if8.leds), 64'h1);
    chk("reset prio pos", 64'(if8.pos), 64'd0);
    chk("reset prio dir", 64'(if8.dir), 64'd0);
    chk("reset prio step", 64'(if8.step), 64'd0);
    if8.enable = 1'b0;
    resetn     = 1'b1;

    // Drain the scoreboard with a bound.
    for (int i = 0; i < 10; i++) begin
      if ((q8.size() + q2.size() + q13.size()) == 0) break;
      cyc(1);
    end
    chk("scoreboard drained", 64'(q8.size() + q2.size() + q13.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
